// File: rtl/fuzz_vector_sequencer.sv
// Fuzz vector sequencer: applies stored vectors to a DUT, folds each wide result into a
// 32-bit MISR, and compares the final signature with a golden value.
module fuzz_vector_sequencer #(
  parameter int          IN_W   = 103,
  parameter int          OUT_W  = 1490,
  parameter int          ADDR_W = 5,
  parameter int          SETTLE = 2,
  parameter logic [31:0] SEED   = 32'hFFFFFFFF,
  parameter logic [31:0] POLY   = 32'h04C11DB7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              vec_we,
  input  logic [ADDR_W-1:0] vec_waddr,
  input  logic [IN_W-1:0]   vec_wdata,
  input  logic [31:0]       golden,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [31:0]       sig,
  output logic [ADDR_W:0]   vec_idx
);

  localparam int NSLICE = (OUT_W + 31) / 32;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, RUN, FOLD, DONE} state_t;

  state_t                  state, state_nxt;
  logic [IN_W-1:0]         mem [DEPTH];
  logic [NSLICE*32-1:0]    shadow;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_W:0]         num_r;
  logic [ADDR_W:0]         num_clamp;
  logic [ADDR_W-1:0]       nxt_addr;
  logic [IN_W-1:0]         rd0;
  logic [31:0]             sig_fold;
  logic                    idle_like, settle_last, fold_last, more_vec;

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ d;
  endfunction

  assign idle_like   = (state == IDLE) || (state == DONE);
  assign num_clamp   = (num_vec > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_vec;
  assign settle_last = (state == RUN)  && (cnt == CNT_W'(SETTLE - 1));
  assign fold_last   = (state == FOLD) && (cnt == CNT_W'(NSLICE - 1));
  assign more_vec    = (vec_idx + (ADDR_W+1)'(1)) < num_r;
  assign nxt_addr    = vec_idx[ADDR_W-1:0] + ADDR_W'(1);
  // A write landing on the start edge must be seen by the run it launches.
  assign rd0         = (vec_we && (vec_waddr == '0)) ? vec_wdata : mem[0];
  assign sig_fold    = misr_step(sig, shadow[31:0]);
  assign busy        = (state == RUN) || (state == FOLD);
  assign done        = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (num_clamp == '0) ? DONE : RUN;
      RUN:        if (settle_last) state_nxt = FOLD;
      FOLD:       if (fold_last) state_nxt = more_vec ? RUN : DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (vec_we && idle_like) mem[vec_waddr] <= vec_wdata;
  end

  // Shadow capture on the last settle cycle, then one slice shifted out per fold cycle.
  always_ff @(posedge clk) begin
    if (settle_last)          shadow <= (NSLICE*32)'(dut_y);
    else if (state == FOLD)   shadow <= shadow >> 32;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in  <= '0;
      sig     <= SEED;
      vec_idx <= '0;
      pass    <= 1'b0;
      cnt     <= '0;
      num_r   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sig     <= SEED;
            vec_idx <= '0;
            cnt     <= '0;
            num_r   <= num_clamp;
            if (num_clamp == '0) begin
              pass   <= (SEED == golden);
              dut_in <= '0;
            end else begin
              pass   <= 1'b0;
              dut_in <= rd0;
            end
          end
        end
        RUN: cnt <= settle_last ? '0 : cnt + CNT_W'(1);
        FOLD: begin
          sig <= sig_fold;
          if (fold_last) begin
            cnt <= '0;
            if (more_vec) begin
              vec_idx <= vec_idx + (ADDR_W+1)'(1);
              dut_in  <= mem[nxt_addr];
            end else begin
              dut_in <= '0;
              pass   <= (sig_fold == golden);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Randomized bench for fuzz_vector_sequencer: a default instance driven by a replicating
// DUT model, plus a narrow instance with y tied low.
module tb_fuzz_vector_sequencer;

  localparam int          IN_W   = 103;
  localparam int          OUT_W  = 1490;
  localparam int          ADDR_W = 5;
  localparam int          DEPTH  = 32;
  localparam int          VCOST  = 49;
  localparam logic [31:0] POLY   = 32'h04C11DB7;

  logic              clk, rst, start, vec_we;
  logic [ADDR_W:0]   num_vec;
  logic [ADDR_W-1:0] vec_waddr;
  logic [IN_W-1:0]   vec_wdata, dut_in;
  logic [31:0]       golden, sig;
  logic [OUT_W-1:0]  dut_y;
  logic [15*IN_W-1:0] rep;
  logic              busy, done, pass;
  logic [ADDR_W:0]   vec_idx;

  logic              s_start, s_busy, s_done, s_pass;
  logic [31:0]       s_sig;
  logic [3:0]        s_dut_in;
  logic [1:0]        s_vec_idx;

  logic [IN_W-1:0]   tmem [DEPTH];
  int                n_cmp, n_bad;

  assign rep   = {15{dut_in}};
  assign dut_y = rep[OUT_W-1:0];

  fuzz_vector_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .vec_we(vec_we),
    .vec_waddr(vec_waddr), .vec_wdata(vec_wdata), .golden(golden), .dut_in(dut_in),
    .dut_y(dut_y), .busy(busy), .done(done), .pass(pass), .sig(sig), .vec_idx(vec_idx)
  );

  fuzz_vector_sequencer #(.IN_W(4), .OUT_W(32), .ADDR_W(1), .SETTLE(1)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .num_vec(2'd1), .vec_we(1'b0),
    .vec_waddr(1'b0), .vec_wdata(4'h0), .golden(32'h0), .dut_in(s_dut_in),
    .dut_y(32'h0), .busy(s_busy), .done(s_done), .pass(s_pass), .sig(s_sig),
    .vec_idx(s_vec_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_vec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[IN_W-1:0];
  endfunction

  // Reference: y bit b mirrors input bit (b mod IN_W); 32-bit slices folded low first.
  function automatic logic [31:0] model_sig(input int n);
    logic [31:0]   s;
    logic [1503:0] y;
    logic          fb;
    int            nn;
    s  = 32'hFFFFFFFF;
    nn = (n > DEPTH) ? DEPTH : n;
    for (int v = 0; v < nn; v++) begin
      y = '0;
      for (int b = 0; b < OUT_W; b++) y[b] = tmem[v][b % IN_W];
      for (int k = 0; k < 47; k++) begin
        fb = s[31];
        s  = {s[30:0], 1'b0} ^ (fb ? POLY : 32'h0) ^ y[32*k +: 32];
      end
    end
    return s;
  endfunction

  task automatic load(input int addr, input logic [IN_W-1:0] d);
    vec_we    = 1'b1;
    vec_waddr = ADDR_W'(addr);
    vec_wdata = d;
    tmem[addr] = d;
    @(posedge clk); #1;
    vec_we = 1'b0;
  endtask

  task automatic run(input int n, input logic [31:0] gold, input int poke_at, output int edges);
    int k;
    start   = 1'b1;
    num_vec = (ADDR_W+1)'(n);
    golden  = gold;
    edges   = 0;
    while (1) begin
      @(posedge clk); #1;
      edges++;
      start  = 1'b0;
      vec_we = 1'b0;
      if (edges == 1 && n > 0) begin
        chk("run_busy", 128'(busy), 128'(1));
        chk("run_dut_in0", 128'(dut_in), 128'(tmem[0]));
        chk("run_idx0", 128'(vec_idx), 128'(0));
      end
      if (edges > 1 && ((edges - 1) % VCOST) == 0 && !done) begin
        k = (edges - 1) / VCOST;
        chk("step_idx", 128'(vec_idx), 128'(k));
        chk("step_dut_in", 128'(dut_in), 128'(tmem[k]));
      end
      if (edges == poke_at) begin
        start     = 1'b1;
        vec_we    = 1'b1;
        vec_waddr = '0;
        vec_wdata = rand_vec();
      end
      if (done || edges >= 3000) break;
    end
    if (!done) chk("run_timeout", 128'(done), 128'(1));
  endtask

  initial begin
    int          e, n, hold;
    logic [31:0] g;
    logic [IN_W-1:0] d;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; vec_we = 1'b0; num_vec = '0; vec_waddr = '0;
    vec_wdata = '0; golden = '0; s_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_pass", 128'(pass), 128'(0));
    chk("rst_sig", 128'(sig), 128'(32'hFFFFFFFF));
    chk("rst_dut_in", 128'(dut_in), 128'(0));
    chk("rst_idx", 128'(vec_idx), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int a = 0; a < DEPTH; a++) load(a, rand_vec());

    // Zero-length run.
    run(0, 32'hFFFFFFFF, -1, e);
    chk("zero_lat", 128'(e), 128'(1));
    chk("zero_pass", 128'(pass), 128'(1));
    chk("zero_sig", 128'(sig), 128'(32'hFFFFFFFF));
    chk("zero_dut_in", 128'(dut_in), 128'(0));

    // 20 vectors, with a start + write poke mid-run that must be ignored.
    g = model_sig(20);
    run(20, g, 100, e);
    chk("v20_lat", 128'(e), 128'(1 + 20 * VCOST));
    chk("v20_sig", 128'(sig), 128'(g));
    chk("v20_pass", 128'(pass), 128'(1));
    chk("v20_dut_in", 128'(dut_in), 128'(0));
    chk("v20_busy", 128'(busy), 128'(0));

    run(20, g ^ 32'h1, -1, e);
    chk("v20_badgold_sig", 128'(sig), 128'(g));
    chk("v20_badgold_pass", 128'(pass), 128'(0));

    hold = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) hold++;
    end
    chk("done_hold", 128'(hold), 128'(50));
    chk("done_sig_frozen", 128'(sig), 128'(g));

    for (int i = 0; i < 3; i++) begin
      n = $urandom_range(1, DEPTH);
      g = model_sig(n);
      run(n, g, -1, e);
      chk("rand_lat", 128'(e), 128'(1 + n * VCOST));
      chk("rand_sig", 128'(sig), 128'(g));
      chk("rand_pass", 128'(pass), 128'(1));
    end

    g = model_sig(45);
    run(45, g, -1, e);
    chk("clamp_lat", 128'(e), 128'(1 + DEPTH * VCOST));
    chk("clamp_sig", 128'(sig), 128'(g));
    chk("clamp_idx", 128'(vec_idx), 128'(DEPTH - 1));

    // Write and start in the same cycle: run must use the new data.
    d = rand_vec();
    tmem[0] = d;
    vec_we = 1'b1; vec_waddr = '0; vec_wdata = d;
    g = model_sig(2);
    run(2, g, -1, e);
    chk("wstart_sig", 128'(sig), 128'(g));
    chk("wstart_pass", 128'(pass), 128'(1));

    // Asynchronous reset in the middle of a fold.
    start = 1'b1; num_vec = 6'd5; golden = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    chk("arst_pass", 128'(pass), 128'(0));
    chk("arst_dut_in", 128'(dut_in), 128'(0));
    chk("arst_sig", 128'(sig), 128'(32'hFFFFFFFF));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_busy", 128'(busy), 128'(0));
    chk("post_rst_done", 128'(done), 128'(0));

    g = model_sig(3);
    run(3, g, -1, e);
    chk("post_rst_sig", 128'(sig), 128'(g));

    // Narrow instance: one vector, y tied low.
    s_start = 1'b1;
    e = 0;
    while (1) begin
      @(posedge clk); #1;
      e++;
      s_start = 1'b0;
      if (s_done || e >= 100) break;
    end
    chk("small_lat", 128'(e), 128'(3));
    chk("small_sig", 128'(s_sig), 128'(32'hFB3EE249));
    chk("small_dut_in", 128'(s_dut_in), 128'(0));
    chk("small_busy", 128'(s_busy), 128'(0));
    chk("small_idx", 128'(s_vec_idx), 128'(0));
    chk("small_pass", 128'(s_pass), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
